edge_det_array: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous level inputs such as buttons, status lines and external strobes. Each channel synchronises and debounces its input, then produces one-cycle rising, falling and mode-qualified event pulses. Events also set sticky pending bits, which drive a single maskable interrupt. The block sits between raw pins and control logic, and is the multi-channel successor to the single-bit, unfiltered `edge_det`.

---
 rtl/edge_det_array.sv | 105 ++++++++++
 tb/tb_edge_det_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_det_array.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// registered rise/fall/event pulses, sticky pending flags and a masked irq.
module edge_det_array #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [NCH-1:0]   sig_in,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   clr,
  input  logic [NCH-1:0]   irq_mask,
  output logic [NCH-1:0]   sig_filt,
  output logic [NCH-1:0]   redge_det,
  output logic [NCH-1:0]   fedge_det,
  output logic [NCH-1:0]   evt,
  output logic [NCH-1:0]   pending,
  output logic             irq
);

  localparam int              CW       = $clog2(FILT_LEN) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
  logic [NCH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NCH-1:0]                  filt_q, filt_d;
  logic [NCH-1:0]                  redge_q, redge_d;
  logic [NCH-1:0]                  fedge_q, fedge_d;
  logic [NCH-1:0]                  evt_q, evt_d;
  logic [NCH-1:0]                  pend_q, pend_d;
  logic [NCH-1:0]                  s_sync;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shifts every clock; ce only gates the filter and beyond.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    redge_d = '0;
    fedge_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ce) begin
        if (s_sync[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // New level has held for FILT_LEN qualified cycles: commit it.
          filt_d[i]  = s_sync[i];
          cnt_d[i]   = '0;
          redge_d[i] = s_sync[i];
          fedge_d[i] = ~s_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    evt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      evt_d[i] = (redge_d[i] & mode[2*i]) | (fedge_d[i] & mode[2*i+1]);
    end
  end

  // A new event outranks a simultaneous clear so it is never lost.
  assign pend_d = (pend_q & ~clr) | evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
      redge_q <= '0;
      fedge_q <= '0;
      evt_q   <= '0;
      pend_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      redge_q <= redge_d;
      fedge_q <= fedge_d;
      evt_q   <= evt_d;
      pend_q  <= pend_d;
    end
  end

  assign sig_filt  = filt_q;
  assign redge_det = redge_q;
  assign fedge_det = fedge_q;
  assign evt       = evt_q;
  assign pending   = pend_q;
  assign irq       = |(pend_q & irq_mask);

endmodule

// File: tb/tb_edge_det_array.sv
// Directed bench for edge_det_array at default parameters (8 ch, 2 sync, filter 4).
module tb_edge_det_array;

  localparam int NCH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic            duty = 1'b0;
  logic [NCH-1:0]  sig_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]  clr;
  logic [NCH-1:0]  irq_mask;
  logic [NCH-1:0]  sig_filt, redge_det, fedge_det, evt, pending;
  logic            irq;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int phase    = 0;
  int r_cnt [NCH] = '{default: 0};
  int f_cnt [NCH] = '{default: 0};
  int e_cnt [NCH] = '{default: 0};
  int r_snap, f_snap, e_snap;
  int exp_evt [4] = '{0, 1, 1, 2};

  edge_det_array dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .sig_in    (sig_in),
    .mode      (mode),
    .clr       (clr),
    .irq_mask  (irq_mask),
    .sig_filt  (sig_filt),
    .redge_det (redge_det),
    .fedge_det (fedge_det),
    .evt       (evt),
    .pending   (pending),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // 1-of-3 clock enable when duty is set
  always @(negedge clk) phase <= (phase == 2) ? 0 : phase + 1;
  assign ce = duty ? (phase == 0) : 1'b1;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= r_cnt[i] + int'(redge_det[i]);
        f_cnt[i] <= f_cnt[i] + int'(fedge_det[i]);
        e_cnt[i] <= e_cnt[i] + int'(evt[i]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    sig_in   = '0;
    mode     = '0;
    clr      = '0;
    irq_mask = '0;
    ticks(2);
    check("rst_sig_filt", 32'(sig_filt), 32'h0);
    check("rst_redge", 32'(redge_det), 32'h0);
    check("rst_fedge", 32'(fedge_det), 32'h0);
    check("rst_evt", 32'(evt), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    ticks(3);

    // basic rising edge latency on ch0
    mode[1:0] = 2'b01;
    irq_mask  = 8'h01;
    sig_in[0] = 1'b1;
    ticks(5);
    check("t1_redge_early", 32'(redge_det[0]), 32'h0);
    check("t1_pending_early", 32'(pending[0]), 32'h0);
    ticks(1);
    check("t1_redge", 32'(redge_det[0]), 32'h1);
    check("t1_evt", 32'(evt[0]), 32'h1);
    check("t1_pending", 32'(pending[0]), 32'h1);
    check("t1_sig_filt", 32'(sig_filt[0]), 32'h1);
    check("t1_irq", 32'(irq), 32'h1);
    ticks(1);
    check("t1_redge_end", 32'(redge_det[0]), 32'h0);
    check("t1_evt_end", 32'(evt[0]), 32'h0);
    check("t1_pending_sticky", 32'(pending[0]), 32'h1);
    irq_mask = 8'h00;
    #1;
    check("t1_irq_masked", 32'(irq), 32'h0);
    clr[0] = 1'b1;
    ticks(1);
    clr[0] = 1'b0;
    check("t1_pending_clr", 32'(pending[0]), 32'h0);

    // glitch rejection on ch1
    mode[3:2] = 2'b01;
    r_snap = r_cnt[1];
    f_snap = f_cnt[1];
    sig_in[1] = 1'b1;
    ticks(3);
    sig_in[1] = 1'b0;
    ticks(12);
    check("t2_glitch3_redge", r_cnt[1] - r_snap, 0);
    check("t2_glitch3_fedge", f_cnt[1] - f_snap, 0);
    check("t2_glitch3_filt", 32'(sig_filt[1]), 32'h0);
    sig_in[1] = 1'b1;
    ticks(4);
    sig_in[1] = 1'b0;
    ticks(15);
    check("t2_pulse4_redge", r_cnt[1] - r_snap, 1);
    check("t2_pulse4_fedge", f_cnt[1] - f_snap, 1);
    check("t2_pulse4_filt", 32'(sig_filt[1]), 32'h0);

    // mode matrix on ch2
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = 2'(m);
      r_snap = r_cnt[2];
      f_snap = f_cnt[2];
      e_snap = e_cnt[2];
      sig_in[2] = 1'b1;
      ticks(10);
      sig_in[2] = 1'b0;
      ticks(10);
      check($sformatf("t3_evt_m%0d", m), e_cnt[2] - e_snap, exp_evt[m]);
      check($sformatf("t3_redge_m%0d", m), r_cnt[2] - r_snap, 1);
      check($sformatf("t3_fedge_m%0d", m), f_cnt[2] - f_snap, 1);
    end

    // ce duty 1-of-3 on ch4
    duty = 1'b1;
    ticks(9);
    r_snap = r_cnt[4];
    sig_in[4] = 1'b1;
    ticks(4);
    sig_in[4] = 1'b0;
    ticks(9);
    check("t4_short_redge", r_cnt[4] - r_snap, 0);
    check("t4_short_filt", 32'(sig_filt[4]), 32'h0);
    sig_in[4] = 1'b1;
    ticks(11);
    check("t4_long_early_filt", 32'(sig_filt[4]), 32'h0);
    ticks(9);
    check("t4_long_filt", 32'(sig_filt[4]), 32'h1);
    check("t4_long_redge", r_cnt[4] - r_snap, 1);
    duty = 1'b0;

    // clear colliding with a new event on ch3
    mode[7:6] = 2'b01;
    irq_mask  = 8'h08;
    sig_in[3] = 1'b1;
    ticks(5);
    check("t5_pending_before", 32'(pending[3]), 32'h0);
    clr[3] = 1'b1;
    ticks(1);
    check("t5_evt", 32'(evt[3]), 32'h1);
    check("t5_pending_set_wins", 32'(pending[3]), 32'h1);
    check("t5_irq_set", 32'(irq), 32'h1);
    ticks(1);
    check("t5_pending_cleared", 32'(pending[3]), 32'h0);
    check("t5_irq_drop", 32'(irq), 32'h0);
    clr[3] = 1'b0;

    // async reset mid-count on all channels
    sig_in   = 8'hFF;
    mode     = 16'h5555;
    irq_mask = 8'hFF;
    ticks(3);
    check("t6_pre_pending", 32'(pending), 32'h06);
    check("t6_pre_filt", 32'(sig_filt), 32'h19);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_filt", 32'(sig_filt), 32'h0);
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    check("t6_rst_redge", 32'(redge_det), 32'h0);
    check("t6_rst_evt", 32'(evt), 32'h0);
    ticks(2);
    rst = 1'b0;
    check("t6_release_redge", 32'(redge_det), 32'h0);
    ticks(5);
    check("t6_early_pending", 32'(pending), 32'h0);
    check("t6_early_filt", 32'(sig_filt), 32'h0);
    ticks(1);
    check("t6_filt", 32'(sig_filt), 32'hFF);
    check("t6_redge", 32'(redge_det), 32'hFF);
    check("t6_evt", 32'(evt), 32'hFF);
    check("t6_pending", 32'(pending), 32'hFF);
    check("t6_irq", 32'(irq), 32'h1);
    ticks(1);
    check("t6_redge_end", 32'(redge_det), 32'h0);
    check("t6_pending_hold", 32'(pending), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
